// File: rtl/axi4_pkg.sv
// ---------------------------------------------------------------------------
// axi4_pkg
// Shared AXI4 beat layouts, payload widths and NoC channel codes for the
// flit packer. Field order within each struct is MSB first, as it appears on
// the packed payload ports.
// ---------------------------------------------------------------------------
package axi4_pkg;

    // Channel codes carried in every flit header.
    localparam logic [2:0] CHANNEL_AW = 3'b001;
    localparam logic [2:0] CHANNEL_W  = 3'b011;
    localparam logic [2:0] CHANNEL_AR = 3'b010;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  user;
    } axi_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [7:0]  user;
    } axi_w_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  user;
    } axi_ar_t;

    localparam int AW_PAYLOAD_W = $bits(axi_aw_t);  // 61
    localparam int W_PAYLOAD_W  = $bits(axi_w_t);   // 81
    localparam int AR_PAYLOAD_W = $bits(axi_ar_t);  // 61

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pk_state_e;

    // Number of flits needed to carry payload_w bits, flit_w bits per flit.
    function automatic int flit_count(input int payload_w, input int flit_w);
        return (payload_w + flit_w - 1) / flit_w;
    endfunction

endpackage

// File: rtl/axi4_rr_arb3.sv
// ---------------------------------------------------------------------------
// axi4_rr_arb3
// Three-request round-robin arbiter. Priority starts at the pointer and walks
// 0 -> 1 -> 2 -> 0. The pointer moves past the winner only when advance is
// high and something was granted.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req[2:0]  : requests (bit0 = AW, bit1 = W, bit2 = AR)
//   advance   : accept the current grant and rotate priority
//   grant[2:0]: one-hot grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module axi4_rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       advance,
    output logic [2:0] grant
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cand;
    logic [1:0] win;
    logic       found;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a signal unassigned, which is what would infer a latch.
        grant = '0;
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        ptr_d = ptr_q;
        // NOTE: blocking assignments here on purpose: cand/found are scratch
        // variables that must update within the same evaluation of the loop.
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = next_idx(cand);
        end
        if (found) begin
            grant[win] = 1'b1;
        end
        if (advance && found) begin
            ptr_d = next_idx(win);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi4_flit_packer.sv
// ---------------------------------------------------------------------------
// axi4_flit_packer
// NoC injection block for an AXI4 master. Accepts AW, W and AR beats,
// round-robin arbitrates between them and serialises each beat into
// ceil(payload/FLIT_DATA_WIDTH) flits, LSB slice first.
//   clk, rst                 : clock, synchronous active-high reset
//   {aw,w,ar}_valid/_ready   : AXI4 beat handshakes
//   {aw,w,ar}_payload        : packed beats (see axi4_pkg structs)
//   flit_valid/flit_ready    : router-side handshake
//   flit_data                : {tail, channel[2:0], data slice}
//   flit_tail                : copy of flit_data MSB
// ---------------------------------------------------------------------------
module axi4_flit_packer
    import axi4_pkg::*;
#(
    parameter int         FLIT_DATA_WIDTH = 32,
    parameter logic [2:0] CHANNEL_MASK    = 3'b111
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       aw_valid,
    output logic                       aw_ready,
    input  logic [AW_PAYLOAD_W-1:0]    aw_payload,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [W_PAYLOAD_W-1:0]     w_payload,
    input  logic                       ar_valid,
    output logic                       ar_ready,
    input  logic [AR_PAYLOAD_W-1:0]    ar_payload,
    output logic                       flit_valid,
    input  logic                       flit_ready,
    output logic [FLIT_DATA_WIDTH+3:0] flit_data,
    output logic                       flit_tail
);

    localparam int AW_NFLITS  = flit_count(AW_PAYLOAD_W, FLIT_DATA_WIDTH);
    localparam int W_NFLITS   = flit_count(W_PAYLOAD_W, FLIT_DATA_WIDTH);
    localparam int AR_NFLITS  = flit_count(AR_PAYLOAD_W, FLIT_DATA_WIDTH);
    localparam int AW_W_MAX   = (AW_NFLITS > W_NFLITS) ? AW_NFLITS : W_NFLITS;
    localparam int MAX_NFLITS = (AW_W_MAX > AR_NFLITS) ? AW_W_MAX : AR_NFLITS;
    localparam int CNT_W      = $clog2(MAX_NFLITS) + 1;
    localparam int BUF_W      = MAX_NFLITS * FLIT_DATA_WIDTH;

    pk_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         chan_q, chan_d;
    logic [BUF_W-1:0]   buf_q, buf_d;

    logic [2:0] req;
    logic [2:0] grant;
    logic       last_flit;
    logic       hs;
    logic       load;

    assign req        = {ar_valid, w_valid, aw_valid} & CHANNEL_MASK;
    assign flit_valid = (state_q == ST_SEND);
    assign last_flit  = (cnt_q == '0);
    assign hs         = flit_valid & flit_ready;
    // A new beat may be taken when empty, or as the final flit leaves, which
    // is what lets packets run back to back without a bubble.
    assign load       = (state_q == ST_IDLE) | (hs & last_flit);

    axi4_rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (load & ~rst),
        .grant   (grant)
    );

    assign aw_ready = load & ~rst & grant[0];
    assign w_ready  = load & ~rst & grant[1];
    assign ar_ready = load & ~rst & grant[2];

    // Data/header are forced to zero while idle so the bus is clean outside
    // packets, including straight after reset.
    assign flit_data = flit_valid ? {last_flit, chan_q, buf_q[FLIT_DATA_WIDTH-1:0]} : '0;
    assign flit_tail = flit_data[FLIT_DATA_WIDTH+3];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        buf_d   = buf_q;
        if (load) begin
            if (grant[0]) begin
                state_d = ST_SEND;
                chan_d  = CHANNEL_AW;
                cnt_d   = CNT_W'(AW_NFLITS - 1);
                buf_d   = BUF_W'(aw_payload);
            end else if (grant[1]) begin
                state_d = ST_SEND;
                chan_d  = CHANNEL_W;
                cnt_d   = CNT_W'(W_NFLITS - 1);
                buf_d   = BUF_W'(w_payload);
            end else if (grant[2]) begin
                state_d = ST_SEND;
                chan_d  = CHANNEL_AR;
                cnt_d   = CNT_W'(AR_NFLITS - 1);
                buf_d   = BUF_W'(ar_payload);
            end else begin
                state_d = ST_IDLE;
            end
        end else if (hs) begin
            buf_d = buf_q >> FLIT_DATA_WIDTH;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chan_q  <= chan_d;
        end
    end

    // NOTE: the shift buffer is a datapath store and is deliberately not
    // reset; it is only observed through flit_data, which is gated by
    // flit_valid, and every packet reloads it before use.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_axi4_flit_packer.sv
module tb_axi4_flit_packer;

    localparam int FDW = 32;
    localparam int FW  = FDW + 4;
    localparam int WDW = 128;
    localparam int WFW = WDW + 4;

    localparam logic [2:0] C_AW = 3'b001;
    localparam logic [2:0] C_W  = 3'b011;
    localparam logic [2:0] C_AR = 3'b010;

    localparam logic [60:0] AW_PL = {8'h12, 32'h8000_1000, 8'd3, 3'b011, 2'b01, 8'h00};
    localparam logic [80:0] W_PL  = {64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1, 8'h00};
    localparam logic [60:0] AR_PL = {8'h34, 32'h4000_2040, 8'd0, 3'b010, 2'b01, 8'h5A};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main instance: 32-bit flits, all channels.
    logic          aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
    logic [60:0]   aw_payload, ar_payload;
    logic [80:0]   w_payload;
    logic          flit_valid, flit_ready, flit_tail;
    logic [FW-1:0] flit_data;

    // Masked instance: W disabled.
    logic          m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_ar_valid, m_ar_ready;
    logic          m_flit_valid, m_flit_ready, m_flit_tail;
    logic [FW-1:0] m_flit_data;

    // Wide instance: 128-bit flits.
    logic           wd_aw_valid, wd_aw_ready, wd_w_valid, wd_w_ready, wd_ar_valid, wd_ar_ready;
    logic           wd_flit_valid, wd_flit_ready, wd_flit_tail;
    logic [WFW-1:0] wd_flit_data;

    axi4_flit_packer #(.FLIT_DATA_WIDTH(FDW), .CHANNEL_MASK(3'b111)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload(aw_payload),
        .w_valid(w_valid), .w_ready(w_ready), .w_payload(w_payload),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload(ar_payload),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_data(flit_data), .flit_tail(flit_tail)
    );

    axi4_flit_packer #(.FLIT_DATA_WIDTH(FDW), .CHANNEL_MASK(3'b101)) dut_mask (
        .clk(clk), .rst(rst),
        .aw_valid(m_aw_valid), .aw_ready(m_aw_ready), .aw_payload(AW_PL),
        .w_valid(m_w_valid), .w_ready(m_w_ready), .w_payload(W_PL),
        .ar_valid(m_ar_valid), .ar_ready(m_ar_ready), .ar_payload(AR_PL),
        .flit_valid(m_flit_valid), .flit_ready(m_flit_ready),
        .flit_data(m_flit_data), .flit_tail(m_flit_tail)
    );

    axi4_flit_packer #(.FLIT_DATA_WIDTH(WDW), .CHANNEL_MASK(3'b111)) dut_wide (
        .clk(clk), .rst(rst),
        .aw_valid(wd_aw_valid), .aw_ready(wd_aw_ready), .aw_payload(AW_PL),
        .w_valid(wd_w_valid), .w_ready(wd_w_ready), .w_payload(W_PL),
        .ar_valid(wd_ar_valid), .ar_ready(wd_ar_ready), .ar_payload(AR_PL),
        .flit_valid(wd_flit_valid), .flit_ready(wd_flit_ready),
        .flit_data(wd_flit_data), .flit_tail(wd_flit_tail)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] exp_flit;

    // Scoreboard side: every accepted flit on the main instance is popped
    // against the next expected flit.
    always @(negedge clk) begin
        if (!rst && flit_valid && flit_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL flit_unexpected: got %h, expected no flit", flit_data);
            end else begin
                exp_flit = exp_q.pop_front();
                if (flit_data !== exp_flit)
                    $display("FAIL flit_data: got %h, expected %h", flit_data, exp_flit);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void push_pkt(input logic [2:0] code, input logic [80:0] pl, input int n);
        logic [80:0] sh;
        for (int k = 0; k < n; k++) begin
            sh = pl >> (FDW * k);
            exp_q.push_back({(k == n - 1), code, sh[FDW-1:0]});
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Waits for the scoreboard to empty, then checks the bus went idle.
    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: got %0d flits outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            n_pass++;
        end
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (flit_valid !== 1'b0)
            $display("FAIL %s_idle: got flit_valid=%b, expected 0", name, flit_valid);
        else
            n_pass++;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        flit_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        n_total++;
        if ({ar_ready, w_ready, aw_ready} !== 3'b000)
            $display("FAIL reset_readies: got %b, expected 000", {ar_ready, w_ready, aw_ready});
        else n_pass++;
        n_total++;
        if (flit_valid !== 1'b0)
            $display("FAIL reset_flit_valid: got %b, expected 0", flit_valid);
        else n_pass++;
        n_total++;
        if (flit_data !== '0)
            $display("FAIL reset_flit_data: got %h, expected 0", flit_data);
        else n_pass++;
        @(posedge clk);
        #1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({flit_valid, flit_tail} !== 2'b00)
            $display("FAIL post_reset_idle: got valid/tail=%b, expected 00", {flit_valid, flit_tail});
        else n_pass++;
        step();
    endtask

    task automatic test_aw_only();
        push_pkt(C_AW, 81'(AW_PL), 2);
        aw_payload = AW_PL;
        aw_valid   = 1'b1;
        flit_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (aw_ready !== 1'b1) $display("FAIL aw_ready_high: got %b, expected 1", aw_ready);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if (aw_ready !== 1'b0) $display("FAIL aw_ready_pulse: got %b, expected 0", aw_ready);
        else n_pass++;
        n_total++;
        if (flit_tail !== 1'b0) $display("FAIL aw_flit0_tail: got %b, expected 0", flit_tail);
        else n_pass++;
        step();
        aw_valid = 1'b0;
        drain("aw_only", 20);
    endtask

    task automatic test_w_stall();
        logic [FW-1:0] hold_exp;
        hold_exp = {1'b0, C_W, W_PL[63:32]};
        push_pkt(C_W, W_PL, 3);
        w_payload  = W_PL;
        w_valid    = 1'b1;
        flit_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (w_ready !== 1'b1) $display("FAIL w_ready_high: got %b, expected 1", w_ready);
        else n_pass++;
        step();
        w_valid = 1'b0;
        step();                         // flit0 handshakes on this edge
        flit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (flit_valid !== 1'b1 || flit_data !== hold_exp)
                $display("FAIL w_stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                         flit_valid, flit_data, hold_exp);
            else n_pass++;
            step();
        end
        flit_ready = 1'b1;
        drain("w_stall", 20);
    endtask

    task automatic test_back_to_back();
        logic [2:0] rdy;
        logic [2:0] exp_rdy;
        logic       exp_tail;
        apply_reset();
        push_pkt(C_AW, 81'(AW_PL), 2);
        push_pkt(C_W, W_PL, 3);
        push_pkt(C_AR, 81'(AR_PL), 2);
        aw_payload = AW_PL; w_payload = W_PL; ar_payload = AR_PL;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
        flit_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            rdy = {ar_ready, w_ready, aw_ready};
            exp_rdy = (cyc == 0) ? 3'b001 : (cyc == 2) ? 3'b010 : (cyc == 5) ? 3'b100 : 3'b000;
            n_total++;
            if (rdy !== exp_rdy)
                $display("FAIL b2b_ready_c%0d: got %b, expected %b", cyc, rdy, exp_rdy);
            else n_pass++;
            if (cyc >= 1) begin
                exp_tail = (cyc == 2) || (cyc == 5) || (cyc == 7);
                n_total++;
                if (flit_valid !== 1'b1 || flit_tail !== exp_tail)
                    $display("FAIL b2b_flit_c%0d: got valid=%b tail=%b, expected valid=1 tail=%b",
                             cyc, flit_valid, flit_tail, exp_tail);
                else n_pass++;
            end
            step();
            if (rdy[0]) aw_valid = 1'b0;
            if (rdy[1]) w_valid  = 1'b0;
            if (rdy[2]) ar_valid = 1'b0;
        end
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        drain("b2b", 20);
    endtask

    task automatic test_reset_mid_packet();
        logic got;
        exp_q.push_back({1'b0, C_W, W_PL[31:0]});
        w_payload  = W_PL;
        w_valid    = 1'b1;
        flit_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (w_ready !== 1'b1) $display("FAIL rst_w_ready: got %b, expected 1", w_ready);
        else n_pass++;
        step();
        w_valid = 1'b0;
        step();                         // W flit0 handshakes on this edge
        n_total++;
        if (exp_q.size() != 0) $display("FAIL rst_w_flit0: got %0d pending, expected 0", exp_q.size());
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (flit_valid !== 1'b0)
                $display("FAIL rst_dropped_c%0d: got flit_valid=%b, expected 0", i, flit_valid);
            else n_pass++;
            step();
        end
        push_pkt(C_AW, 81'(AW_PL), 2);
        push_pkt(C_W, W_PL, 3);
        aw_payload = AW_PL;
        aw_valid = 1'b1; w_valid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({ar_ready, w_ready, aw_ready} !== 3'b001)
            $display("FAIL rst_first_grant: got %b, expected 001", {ar_ready, w_ready, aw_ready});
        else n_pass++;
        step();
        aw_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = w_ready;
            step();
        end
        w_valid = 1'b0;
        n_total++;
        if (!got) $display("FAIL rst_w_accept: got no w_ready, expected one within 10 cycles");
        else n_pass++;
        drain("rst_mid", 20);
    endtask

    task automatic test_mask();
        logic [FW-1:0] m_exp[2];
        logic [80:0]   sh;
        int            idx;
        int            nflits;
        sh = 81'(AR_PL);
        m_exp[0] = {1'b0, C_AR, sh[31:0]};
        sh = sh >> FDW;
        m_exp[1] = {1'b1, C_AR, sh[31:0]};
        idx = 0;
        nflits = 0;
        m_flit_ready = 1'b1;
        m_w_valid = 1'b1;
        m_ar_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            n_total++;
            if ({m_w_ready, m_aw_ready} !== 2'b00)
                $display("FAIL mask_w_ready_c%0d: got w/aw=%b, expected 00", cyc, {m_w_ready, m_aw_ready});
            else n_pass++;
            if (m_flit_valid) begin
                n_total++;
                if (m_flit_data !== m_exp[idx] || m_flit_tail !== idx[0])
                    $display("FAIL mask_flit_c%0d: got %h, expected %h", cyc, m_flit_data, m_exp[idx]);
                else n_pass++;
                idx = 1 - idx;
                nflits++;
            end
            step();
        end
        m_w_valid = 1'b0;
        m_ar_valid = 1'b0;
        n_total++;
        if (nflits != 11) $display("FAIL mask_flit_count: got %0d, expected 11", nflits);
        else n_pass++;
        for (int i = 0; i < 10 && m_flit_valid; i++) step();
    endtask

    task automatic test_wide();
        logic [WFW-1:0] exp_w;
        logic           rdy;
        wd_flit_ready = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            case (ch)
                0: begin wd_aw_valid = 1'b1; exp_w = {1'b1, C_AW, 128'(AW_PL)}; end
                1: begin wd_w_valid  = 1'b1; exp_w = {1'b1, C_W,  128'(W_PL)};  end
                default: begin wd_ar_valid = 1'b1; exp_w = {1'b1, C_AR, 128'(AR_PL)}; end
            endcase
            @(negedge clk);
            rdy = (ch == 0) ? wd_aw_ready : (ch == 1) ? wd_w_ready : wd_ar_ready;
            n_total++;
            if (rdy !== 1'b1) $display("FAIL wide_ready_ch%0d: got %b, expected 1", ch, rdy);
            else n_pass++;
            step();
            wd_aw_valid = 1'b0; wd_w_valid = 1'b0; wd_ar_valid = 1'b0;
            @(negedge clk);
            n_total++;
            if (wd_flit_valid !== 1'b1 || wd_flit_tail !== 1'b1 || wd_flit_data !== exp_w)
                $display("FAIL wide_flit_ch%0d: got valid=%b data=%h, expected valid=1 data=%h",
                         ch, wd_flit_valid, wd_flit_data, exp_w);
            else n_pass++;
            if (ch == 1) begin
                n_total++;
                if (wd_flit_data[127:81] !== 47'd0)
                    $display("FAIL wide_w_pad: got %h, expected 0", wd_flit_data[127:81]);
                else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        aw_payload = '0; w_payload = '0; ar_payload = '0;
        flit_ready = 1'b0;
        m_aw_valid = 1'b0; m_w_valid = 1'b0; m_ar_valid = 1'b0; m_flit_ready = 1'b0;
        wd_aw_valid = 1'b0; wd_w_valid = 1'b0; wd_ar_valid = 1'b0; wd_flit_ready = 1'b0;

        test_reset();
        test_aw_only();
        test_w_stall();
        test_back_to_back();
        test_reset_mid_packet();
        test_mask();
        test_wide();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
